// File: rtl/param_reg_arb_pkg.sv
// rtl/param_reg_arb_pkg.sv - shared FSM encoding and default sizes for param_reg_arb
package param_reg_arb_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/param_reg_arb_rr_arbiter.sv
// rtl/param_reg_arb_rr_arbiter.sv - combinational round-robin winner search
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  int idx;

  // Scan offsets from the highest down so the set bit closest to ptr is kept last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        winner  = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_reg_arb.sv
// rtl/param_reg_arb.sv - round-robin arbitrated shared data register
module param_reg_arb
  import param_reg_arb_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       d_in,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         d_out,
  output logic [$clog2(N)-1:0] owner,
  output logic                 upd,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  state_e          state;
  state_e          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner_q;
  logic [IW-1:0]   arb_winner;
  logic            arb_any;
  logic            grant_ok;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  // A latched winner only gets served if it is still requesting in GRANT.
  assign grant_ok = req[winner_q];

  // Next-state decision: IDLE -> GRANT on any request, GRANT -> DONE or back to IDLE on withdrawal.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arb_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = grant_ok ? ST_DONE : ST_IDLE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Winner latch, capture, pointer advance and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      winner_q <= '0;
      d_out    <= '0;
      owner    <= '0;
      gnt      <= '0;
      upd      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      gnt  <= '0;
      upd  <= 1'b0;
      busy <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (arb_any) winner_q <= arb_winner;
        end
        ST_GRANT: begin
          if (grant_ok) begin
            gnt   <= {{(N-1){1'b0}}, 1'b1} << winner_q;
            d_out <= d_in[int'(winner_q)*W +: W];
            owner <= winner_q;
          end
        end
        ST_DONE: begin
          upd <= 1'b1;
          ptr <= (winner_q == IW'(N - 1)) ? '0 : winner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_reg_arb.sv
// tb/tb_param_reg_arb.sv - scoreboard bench for param_reg_arb
module tb_param_reg_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] d_in;
  logic [3:0]  gnt;
  logic [7:0]  d_out;
  logic [1:0]  owner;
  logic        upd;
  logic        busy;

  typedef struct {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_cyc[$];
  int   checks   = 0;
  int   failures = 0;
  int   gnt_cnt  = 0;
  int   upd_cnt  = 0;
  int   cyc      = 0;
  logic [3:0] prev_gnt = '0;

  param_reg_arb #(.W(8), .N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .d_in  (d_in),
    .gnt   (gnt),
    .d_out (d_out),
    .owner (owner),
    .upd   (upd),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.own = o;
    e.dat = d;
    return e;
  endfunction

  // Monitor: grant/update scoreboard plus per-cycle protocol rules.
  always @(negedge clk) begin
    if (!reset) begin
      chk("gnt_onehot", {31'd0, $countones(gnt) <= 1}, 32'd1);
      if (upd) chk("upd_after_gnt", {28'd0, prev_gnt}, {28'd0, gnt_q_expected_prev()});
      if (gnt != 4'b0) begin
        gnt_cnt++;
        gnt_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("gnt_unexpected", {28'd0, gnt}, 32'd0);
        else                   chk("gnt_index", {28'd0, gnt}, {28'd0, 4'b0001 << exp_q[0].own});
      end
      if (upd) begin
        upd_cnt++;
        if (exp_q.size() == 0) chk("upd_unexpected", 32'd1, 32'd0);
        else begin
          chk("owner", {30'd0, owner}, {30'd0, exp_q[0].own});
          chk("d_out", {24'd0, d_out}, {24'd0, exp_q[0].dat});
          void'(exp_q.pop_front());
        end
      end
    end
    prev_gnt = gnt;
  end

  // upd is legal only right after a grant to the entry being retired.
  function automatic logic [3:0] gnt_q_expected_prev();
    if (exp_q.size() == 0) return 4'b1111;
    return 4'b0001 << exp_q[0].own;
  endfunction

  task automatic run_held(input logic [3:0] mask, input int n, input string name);
    int start;
    int budget;
    start  = gnt_cnt;
    budget = 0;
    req    = mask;
    while (gnt_cnt < start + n && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    req = 4'b0;
    chk({name, "_grants"}, gnt_cnt - start, n);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    req   = 4'b0;
    d_in  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_d_out", {24'd0, d_out}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_gnt",   {28'd0, gnt},   32'd0);
    chk("rst_upd",   {31'd0, upd},   32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request with cycle-exact latency.
    d_in[7:0] = 8'hA5;
    exp_q.push_back(mk(2'd0, 8'hA5));
    req = 4'b0001;
    @(negedge clk);
    chk("single_busy_grant_state", {31'd0, busy}, 32'd1);
    chk("single_no_gnt_yet", {28'd0, gnt}, 32'd0);
    @(negedge clk);
    chk("single_gnt", {28'd0, gnt}, 32'd1);
    chk("single_d_out", {24'd0, d_out}, 32'hA5);
    req = 4'b0;
    @(negedge clk);
    chk("single_upd", {31'd0, upd}, 32'd1);
    chk("single_gnt_cleared", {28'd0, gnt}, 32'd0);
    chk("single_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("single_upd_one_cycle", {31'd0, upd}, 32'd0);
    repeat (2) @(negedge clk);

    // Fresh reset so the rotation starts at ptr=0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // All requesting: strict rotation 0,1,2,3,0 at one grant per 3 cycles.
    d_in = 32'h44332211;
    exp_q.push_back(mk(2'd0, 8'h11));
    exp_q.push_back(mk(2'd1, 8'h22));
    exp_q.push_back(mk(2'd2, 8'h33));
    exp_q.push_back(mk(2'd3, 8'h44));
    exp_q.push_back(mk(2'd0, 8'h11));
    base = gnt_cyc.size();
    run_held(4'b1111, 5, "rotate");
    if (gnt_cyc.size() >= base + 5) begin
      chk("rotate_spacing_1", gnt_cyc[base+1] - gnt_cyc[base], 3);
      chk("rotate_spacing_all", gnt_cyc[base+4] - gnt_cyc[base], 12);
    end else chk("rotate_gnt_count", gnt_cyc.size() - base, 5);

    // Wrap-around: grant 3, then 1001 goes 0 then 3.
    d_in = 32'h88000077;
    exp_q.push_back(mk(2'd3, 8'h88));
    run_held(4'b1000, 1, "wrap_first");
    exp_q.push_back(mk(2'd0, 8'h77));
    exp_q.push_back(mk(2'd3, 8'h88));
    run_held(4'b1001, 2, "wrap");

    // Withdrawal: requester 2 drops out after one sampled edge.
    d_in = 32'h00990000;
    base = upd_cnt;
    req  = 4'b0100;
    @(negedge clk);
    chk("withdraw_busy", {31'd0, busy}, 32'd1);
    req = 4'b0;
    repeat (4) @(negedge clk);
    chk("withdraw_busy_low", {31'd0, busy}, 32'd0);
    chk("withdraw_d_out", {24'd0, d_out}, 32'h88);
    chk("withdraw_no_upd", upd_cnt - base, 0);

    // Pointer not advanced by the withdrawal: 0110 from ptr=0 picks 1.
    d_in = 32'h00993C00;
    exp_q.push_back(mk(2'd1, 8'h3C));
    run_held(4'b0110, 1, "after_withdraw");

    // Reset during GRANT aborts the capture.
    d_in[15:8] = 8'h5A;
    req = 4'b0010;
    @(negedge clk);
    chk("abort_in_grant", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_d_out", {24'd0, d_out}, 32'd0);
    chk("abort_gnt",   {28'd0, gnt},   32'd0);
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_owner", {30'd0, owner}, 32'd0);
    req = 4'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ptr back at 0: all requesting grants 0 first.
    d_in = 32'h44332211;
    exp_q.push_back(mk(2'd0, 8'h11));
    run_held(4'b1111, 1, "post_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
